// File: rtl/seg7_scan_arbiter.sv
// 8-digit multiplexed 7-segment scan controller with a round-robin arbitrated
// digit buffer, per-slot blanking, PWM brightness and active-low pin drive.
module seg7_scan_arbiter #(
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [5:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [5:0] b_data,
  output logic       b_ready,
  input  logic [2:0] bright,
  output logic [7:0] digits,
  output logic [7:0] number
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  typedef enum logic {PH_BLANK, PH_DISPLAY} phase_e;
  typedef enum logic {SIDE_A, SIDE_B} side_e;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } entry_t;

  localparam entry_t BLANK_ENTRY = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

  // Active-low segment pattern {dp,g..a}; blank forces every segment off.
  function automatic logic [7:0] decode(input entry_t e);
    logic [6:0] seg;
    seg = 7'h7F;
    case (e.hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    if (e.blank) return 8'hFF;
    return {~e.dp, seg};
  endfunction

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------
  side_e      pri;
  logic       wr_en;
  logic [2:0] wr_addr;
  entry_t     wr_data;
  entry_t     buffer [8];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave it unassigned and infer a latch.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (RST) begin
      if (a_valid && (!b_valid || pri == SIDE_A)) a_ready = 1'b1;
      else if (b_valid)                           b_ready = 1'b1;
    end
  end

  always_comb begin
    wr_en   = a_ready || b_ready;
    wr_addr = a_ready ? a_addr : b_addr;
    wr_data = a_ready ? entry_t'(a_data) : entry_t'(b_data);
  end

  // NOTE: the buffer is only eight small entries and must power up blank, so
  // it is built from flops with an explicit reset rather than a RAM macro.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) buffer[i] <= BLANK_ENTRY;
      pri <= SIDE_A;
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_data;
      pri             <= a_ready ? SIDE_B : SIDE_A;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counters and per-slot snapshot
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] slot_cnt;
  logic [2:0]       idx;
  entry_t           snap_entry;
  logic [2:0]       snap_bright;

  // NOTE: all clocked state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      snap_entry  <= BLANK_ENTRY;
      snap_bright <= '0;
    end else if (slot_cnt == BLANK_END) begin
      snap_entry  <= buffer[idx];
      snap_bright <= bright;
    end
  end

  // ---------------------------------------------------------------------------
  // Output generation
  // ---------------------------------------------------------------------------
  phase_e     phase;
  entry_t     cur_entry;
  logic [2:0] cur_bright;
  logic       pwm_on;
  logic [7:0] digits_nxt;
  logic [7:0] number_nxt;

  // The snapshot edge itself already drives lit outputs, so the value being
  // captured is forwarded straight from the buffer on that cycle.
  always_comb begin
    if (slot_cnt == BLANK_END) begin
      cur_entry  = buffer[idx];
      cur_bright = bright;
    end else begin
      cur_entry  = snap_entry;
      cur_bright = snap_bright;
    end
    phase      = (slot_cnt < BLANK_END) ? PH_BLANK : PH_DISPLAY;
    pwm_on     = slot_cnt[2:0] <= cur_bright;
    digits_nxt = 8'hFF;
    number_nxt = 8'hFF;
    if (phase == PH_DISPLAY && pwm_on) begin
      digits_nxt = ~(8'b1 << idx);
      number_nxt = decode(cur_entry);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      digits <= 8'hFF;
      number <= 8'hFF;
    end else begin
      digits <= digits_nxt;
      number <= number_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Directed self-checking bench for seg7_scan_arbiter with a shortened scan
// (32-cycle slots, 4 blanking cycles) so several full scans fit in one run.
module tb_seg7_scan_arbiter;

  localparam int SD = 32;
  localparam int BC = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [2:0] a_addr, b_addr, bright;
  logic [5:0] a_data, b_data;
  logic [7:0] digits, number;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_arbiter #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .bright(bright), .digits(digits), .number(number)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // pos counts edges since the last reset edge; outputs visible after a tick
  // belong to pre-edge slot (pos-1)%SD of digit ((pos-1)/SD)%8.
  task automatic tick();
    logic r;
    r = RST;
    @(posedge CLK);
    #1;
    if (!r) pos = 0;
    else    pos++;
  endtask

  // Advance until the next edge is the one at slot sl of digit ix.
  task automatic goto(input int ix, input int sl);
    int guard;
    guard = 0;
    while (!((pos % SD) == sl && ((pos / SD) % 8) == ix) && guard < 8 * SD + 2) begin
      tick();
      guard++;
    end
    if (guard >= 8 * SD + 2) check("goto_timeout", guard, 0);
  endtask

  function automatic logic [7:0] sel(input int k);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << k);
  endfunction

  initial begin
    int bad, lit, multi, lead, errs, on_cnt;
    bit got_first;
    a_valid = 1'b1; a_addr = 3'd0; a_data = 6'h00;
    b_valid = 1'b1; b_addr = 3'd1; b_data = 6'h01;
    bright  = 3'd7;

    // Reset held with both requesters valid.
    repeat (5) tick();
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_digits", digits, 8'hFF);
    check("rst_number", number, 8'hFF);
    RST = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // First full scan: all entries blank, selects still follow PWM.
    bad = 0; lit = 0; multi = 0;
    repeat (8 * SD) begin
      tick();
      if (number !== 8'hFF) bad++;
      if (digits !== 8'hFF) lit++;
      if ($countones(~digits) > 1) multi++;
    end
    check("blank_scan_number", bad, 0);
    check("blank_scan_lit_cycles", lit, 8 * (SD - BC));
    check("one_digit_low", multi, 0);

    // Single writes from A: hex k into digit k.
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_addr = 3'(k); a_data = 6'(k);
      tick();
    end
    a_valid = 1'b0;
    goto(0, 0);
    for (int k = 0; k < 8; k++) begin
      lead = 0; errs = 0; got_first = 1'b0;
      for (int s = 0; s < SD; s++) begin
        tick();
        if (!got_first && digits === 8'hFF && number === 8'hFF) lead++;
        else if (!got_first) begin
          got_first = 1'b1;
          check($sformatf("slot%0d_digits", k), digits, sel(k));
          check($sformatf("slot%0d_number", k), number, seg_tab[k]);
        end else if (digits !== sel(k) || number !== seg_tab[k]) errs++;
      end
      check($sformatf("slot%0d_blank_len", k), lead, BC);
      check($sformatf("slot%0d_steady", k), errs, 0);
    end

    // Contention on addr 6; A wrote last, so B holds priority first.
    a_valid = 1'b1; a_addr = 3'd6; a_data = 6'h0A;
    b_valid = 1'b1; b_addr = 3'd6; b_data = 6'h0B;
    for (int g = 0; g < 4; g++) begin
      #1;
      check($sformatf("cont%0d_a_ready", g), a_ready, (g % 2 == 1));
      check($sformatf("cont%0d_b_ready", g), b_ready, (g % 2 == 0));
      tick();
    end
    b_valid = 1'b0; a_addr = 3'd7; a_data = 6'h07;
    #1;
    check("lone_a_ready", a_ready, 1'b1);
    check("lone_b_ready", b_ready, 1'b0);
    tick();
    a_valid = 1'b0;
    goto(6, 8);
    tick();
    check("cont_last_wins_number", number, seg_tab[10]);
    check("cont_last_wins_digits", digits, sel(6));

    // Brightness 0 on digit 3 = {blank 0, dp 1, hex 8}; bright raised mid-slot.
    goto(2, 0);
    bright = 3'd0;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 6'b011000;
    tick();
    a_valid = 1'b0;
    goto(3, 0);
    errs = 0; on_cnt = 0;
    for (int s = 0; s < SD; s++) begin
      if (s == 10) bright = 3'd7;
      tick();
      if (digits !== 8'hFF) on_cnt++;
      if (s >= BC && s % 8 == 0) begin
        if (digits !== sel(3) || number !== 8'h00) errs++;
      end else if (digits !== 8'hFF || number !== 8'hFF) errs++;
    end
    check("dim_pattern", errs, 0);
    check("dim_on_cycles", on_cnt, 3);
    on_cnt = 0;
    for (int s = 0; s < SD; s++) begin
      tick();
      if (s >= BC && digits === sel(4) && number === seg_tab[4]) on_cnt++;
    end
    check("bright_next_slot_on_cycles", on_cnt, SD - BC);

    // Mid-slot write to the digit currently displayed.
    goto(2, 10);
    a_valid = 1'b1; a_addr = 3'd2; a_data = 6'h0F;
    tick();
    a_valid = 1'b0;
    check("midslot_old_number", number, seg_tab[2]);
    check("midslot_old_digits", digits, sel(2));
    errs = 0;
    for (int s = 11; s < SD; s++) begin
      tick();
      if (number !== seg_tab[2] || digits !== sel(2)) errs++;
    end
    check("midslot_rest_of_slot", errs, 0);
    goto(2, 8);
    tick();
    check("midslot_next_visit_number", number, seg_tab[15]);
    check("midslot_next_visit_digits", digits, sel(2));

    // One-cycle reset during digit 5 display, with a write presented.
    goto(5, 10);
    tick();
    check("pre_reset_number", number, seg_tab[5]);
    RST = 1'b0;
    a_valid = 1'b1; a_addr = 3'd0; a_data = 6'h00;
    #1;
    check("midrst_a_ready", a_ready, 1'b0);
    tick();
    check("midrst_digits", digits, 8'hFF);
    check("midrst_number", number, 8'hFF);
    RST = 1'b1; a_valid = 1'b0;
    bad = 0;
    repeat (BC) begin
      tick();
      if (digits !== 8'hFF || number !== 8'hFF) bad++;
    end
    check("post_rst_blank", bad, 0);
    tick();
    check("post_rst_first_digits", digits, sel(0));
    check("post_rst_dropped_write", number, 8'hFF);
    goto(2, 8);
    tick();
    check("post_rst_buf2_number", number, 8'hFF);
    check("post_rst_buf2_digits", digits, sel(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
